if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage wrapped around the instruction ROM.
//   - Upstream half: owns the PC register and drives pc_o/ce_o into the ROM.
//   - The ROM returns inst_i combinationally in the same cycle.
//   - Downstream half: registers {pc, inst, valid} into the IF/ID latch for decode.
//   - Supports pipeline stall, branch redirect (MIPS delay slot kept) and exception flush.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset
//   PC_STEP   32'd4          sequential PC increment
// PORTS
//   clk              in   1   clock; all state updates on posedge
//   rst              in   1   synchronous reset, ACTIVE-LOW (0 = reset)
//   stall_i          in   1   hold PC and IF/ID latch this cycle
//   branch_i         in   1   redirect PC to branch_target_i
//   branch_target_i  in   32  branch/jump target address
//   flush_i          in   1   exception/eret flush; redirect to flush_pc_i
//   flush_pc_i       in   32  flush target address
//   inst_i           in   32  instruction from ROM for address pc_o (combinational)
//   pc_o             out  32  fetch address to ROM
//   ce_o             out  1   ROM chip enable
//   id_pc_o          out  32  IF/ID: PC of latched instruction
//   id_inst_o        out  32  IF/ID: latched instruction (0 = nop when invalid)
//   id_valid_o       out  1   IF/ID: latched instruction is valid
//   misalign_o       out  1   1-cycle pulse: redirect target had addr[1:0] != 0
// BEHAVIOUR
//   Reset (rst==0 at posedge):
//   - state=S_IDLE; pc_o=RESET_PC; ce_o=0.
//   - id_pc_o=0, id_inst_o=0, id_valid_o=0, misalign_o=0.
//   - Reset overrides every other input, mid-operation included.
//   FSM:
//   - S_IDLE -> S_RUN on the first posedge with rst==1; sets ce_o=1, pc_o stays RESET_PC.
//   - S_RUN  -> S_STALL when stall_i=1 and flush_i=0.
//   - S_STALL -> S_RUN when stall_i=0 or flush_i=1.
//   - ce_o=1 in S_RUN and S_STALL.
//   - In S_IDLE, IF/ID holds invalid, and stall/branch/flush are ignored.
//   Per posedge in S_RUN/S_STALL, priority flush > stall > branch > sequential:
//   - flush_i:
//       pc_o <= {flush_pc_i[31:2],2'b00}; id_inst_o <= 0; id_valid_o <= 0; id_pc_o <= 0.
//       Applies even while stalled.
//   - stall_i:
//       pc_o and all id_* hold their values; branch_i is ignored.
//       Upstream must hold branch_i until the stall drops.
//   - branch_i:
//       pc_o <= {branch_target_i[31:2],2'b00}.
//       The current fetch (delay slot) is latched: id_pc_o <= pc_o, id_inst_o <= inst_i, id_valid_o <= 1.
//   - sequential:
//       pc_o <= pc_o + PC_STEP, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
//       id_pc_o <= pc_o; id_inst_o <= inst_i; id_valid_o <= 1.
//   Latency:
//   - Instruction addressed by pc_o in cycle N appears on id_inst_o in cycle N+1.
//   - Redirect: target is on pc_o the cycle after the branch/flush posedge.
//   misalign_o:
//   - Registered.
//   - 1 for exactly one cycle after an accepted redirect whose target had [1:0] != 0.
//   - 0 otherwise, including for a branch that is suppressed by stall.
//   Simultaneous events:
//   - flush+branch: flush wins, branch lost.
//   - stall+flush: flush executes and FSM moves to S_RUN.
// TESTING
//   1. Hold rst=0 for 3 cycles -> pc_o=0, ce_o=0, id_valid_o=0. Release -> ce_o=1, pc_o=0.
//      Next cycles: pc_o=4,8,12; id_pc_o=0,4,8 with id_inst_o equal to ROM words 0,1,2.
//   2. At pc_o=0x8 assert branch_i, target 0x40 -> id_pc_o=0x8 valid (delay slot). Next pc_o=0x40, then id_pc_o=0x40.
//   3. stall_i=1 for 3 cycles at pc_o=0xC -> pc_o, id_pc_o, id_inst_o frozen. Release -> pc_o=0x10.
//   4. During stall assert flush_i, flush_pc_i=0x20 -> next cycle pc_o=0x20, id_valid_o=0, id_inst_o=0, FSM=S_RUN.
//   5. Branch to 0x42 -> pc_o=0x40, misalign_o=1 for one cycle. Force pc_o to 0xFFFF_FFFC via branch -> next pc_o=0x0.
//   6. rst=0 mid-run with branch_i=1 -> pc_o=RESET_PC, ce_o=0, id_valid_o=0, misalign_o=0 on that posedge.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, ROM interface and IF/ID latch
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic        ce_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc_o       <= RESET_PC;
            ce_o       <= 1'b0;
            id_pc_o    <= 32'd0;
            id_inst_o  <= 32'd0;
            id_valid_o <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    // First live cycle only enables the ROM; the first fetch is RESET_PC.
                    state      <= S_RUN;
                    ce_o       <= 1'b1;
                    id_valid_o <= 1'b0;
                end
                S_RUN, S_STALL: begin
                    if (flush_i) begin
                        state      <= S_RUN;
                        pc_o       <= {flush_pc_i[31:2], 2'b00};
                        id_pc_o    <= 32'd0;
                        id_inst_o  <= 32'd0;
                        id_valid_o <= 1'b0;
                        misalign_o <= |flush_pc_i[1:0];
                    end else if (stall_i) begin
                        state <= S_STALL;
                    end else begin
                        // Branch or not, the instruction fetched now is latched (delay slot).
                        state      <= S_RUN;
                        id_pc_o    <= pc_o;
                        id_inst_o  <= inst_i;
                        id_valid_o <= 1'b1;
                        if (branch_i) begin
                            pc_o       <= {branch_target_i[31:2], 2'b00};
                            misalign_o <= |branch_target_i[1:0];
                        end else begin
                            pc_o <= pc_o + PC_STEP;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ce_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage with a fetch-stream model
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] inst_i;
    logic [31:0] pc_o;
    logic        ce_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // model of the visible fetch stream
    bit          m_live;
    logic [31:0] m_pc, m_idpc, m_idinst;
    logic        m_ce, m_idvalid, m_mis;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    assign inst_i = rom_word(pc_o);

    if_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i),
        .branch_target_i(branch_target_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .inst_i(inst_i), .pc_o(pc_o), .ce_o(ce_o), .id_pc_o(id_pc_o),
        .id_inst_o(id_inst_o), .id_valid_o(id_valid_o), .misalign_o(misalign_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what each posedge must do to the fetch stream, given the inputs applied.
    always @(posedge clk) begin
        logic [31:0] cur;
        cur = m_pc;
        if (!rst) begin
            m_live = 0; m_pc = 32'h0; m_ce = 0;
            m_idpc = 0; m_idinst = 0; m_idvalid = 0; m_mis = 0;
        end else if (!m_live) begin
            m_live = 1; m_ce = 1; m_mis = 0;
        end else begin
            m_mis = 0;
            if (flush_i) begin
                m_pc = word_align(flush_pc_i);
                m_mis = (flush_pc_i % 4) != 0;
                m_idpc = 0; m_idinst = 0; m_idvalid = 0;
            end else if (!stall_i) begin
                m_idpc = cur; m_idinst = rom_word(cur); m_idvalid = 1;
                if (branch_i) begin
                    m_pc = word_align(branch_target_i);
                    m_mis = (branch_target_i % 4) != 0;
                end else begin
                    m_pc = cur + 32'd4;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (check_en) begin
            check("pc", pc_o, m_pc);
            check("ce", {31'd0, ce_o}, {31'd0, m_ce});
            check("id_pc", id_pc_o, m_idpc);
            check("id_inst", id_inst_o, m_idinst);
            check("id_valid", {31'd0, id_valid_o}, {31'd0, m_idvalid});
            check("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                         input logic f, input logic [31:0] fp);
        rst = r; stall_i = s; branch_i = b; branch_target_i = bt; flush_i = f; flush_pc_i = fp;
        tick();
    endtask

    initial begin
        rst = 0; stall_i = 0; branch_i = 0; branch_target_i = 0; flush_i = 0; flush_pc_i = 0;
        tick();
        check_en = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("lit_reset_pc", pc_o, 32'h0);
        check("lit_reset_ce", {31'd0, ce_o}, 32'd0);
        check("lit_reset_valid", {31'd0, id_valid_o}, 32'd0);

        drive(1, 0, 0, 0, 0, 0);
        check("lit_start_ce", {31'd0, ce_o}, 32'd1);
        check("lit_start_pc", pc_o, 32'h0);
        drive(1, 0, 0, 0, 0, 0);
        check("lit_seq_idpc0", id_pc_o, 32'h0);
        check("lit_seq_idinst0", id_inst_o, 32'hC0DE_0000);
        drive(1, 0, 0, 0, 0, 0);
        check("lit_seq_pc8", pc_o, 32'h8);

        // branch at pc 8 to 0x40: delay slot at 8 is latched
        drive(1, 0, 1, 32'h40, 0, 0);
        check("lit_br_pc", pc_o, 32'h40);
        check("lit_br_slot", id_pc_o, 32'h8);
        check("lit_br_slot_inst", id_inst_o, 32'hC0DE_0008);
        drive(1, 0, 0, 0, 0, 0);
        check("lit_br_target_idpc", id_pc_o, 32'h40);
        drive(1, 0, 0, 0, 0, 0);

        // stall three cycles at 0x48
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0);
        check("lit_stall_pc", pc_o, 32'h48);
        check("lit_stall_idpc", id_pc_o, 32'h44);
        drive(1, 0, 0, 0, 0, 0);
        check("lit_unstall_pc", pc_o, 32'h4C);

        // flush during stall, simultaneous branch is lost
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 32'h300, 1, 32'h20);
        check("lit_flush_pc", pc_o, 32'h20);
        check("lit_flush_valid", {31'd0, id_valid_o}, 32'd0);
        check("lit_flush_inst", id_inst_o, 32'h0);
        drive(1, 0, 0, 0, 0, 0);
        check("lit_after_flush_valid", {31'd0, id_valid_o}, 32'd1);

        // branch suppressed by stall, then taken once stall drops
        drive(1, 1, 1, 32'h102, 0, 0);
        check("lit_stalled_br_mis", {31'd0, misalign_o}, 32'd0);
        drive(1, 0, 1, 32'h100, 0, 0);
        check("lit_br_after_stall", pc_o, 32'h100);

        // misaligned branch target
        drive(1, 0, 1, 32'h42, 0, 0);
        check("lit_mis_pc", pc_o, 32'h40);
        check("lit_mis_pulse", {31'd0, misalign_o}, 32'd1);
        drive(1, 0, 0, 0, 0, 0);
        check("lit_mis_clear", {31'd0, misalign_o}, 32'd0);

        // wrap-around
        drive(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("lit_wrap", pc_o, 32'h0);

        // flush and branch together, plus misaligned flush target
        drive(1, 0, 1, 32'h300, 1, 32'h200);
        check("lit_flush_wins", pc_o, 32'h200);
        drive(1, 0, 0, 0, 1, 32'h203);
        check("lit_flush_mis", {31'd0, misalign_o}, 32'd1);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        // reset mid-run with a branch pending
        drive(0, 0, 1, 32'h500, 0, 0);
        check("lit_midrst_pc", pc_o, 32'h0);
        check("lit_midrst_ce", {31'd0, ce_o}, 32'd0);
        check("lit_midrst_valid", {31'd0, id_valid_o}, 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("lit_restart_pc", pc_o, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
